icache_refill_ctrl: RTL and testbench

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

---
 rtl/icache_refill_ctrl_pkg.sv | 22 ++
 rtl/icache_refill_ctrl_if.sv | 60 ++++++
 rtl/icache_refill_ctrl.sv | 131 +++++++++++++
 tb/tb_icache_refill_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared I-cache types and widths: set-index and way-select sizes, the LRU
// command encoding, and a helper that aligns an address to its cache line.
package icache_refill_ctrl_pkg;

   localparam int ICache_index_bit    = 8;
   localparam int ICache_position_bit = 2;   // 4-way

   typedef logic [ICache_index_bit-1:0]    index_t;
   typedef logic [ICache_position_bit-1:0] position_t;

   // MODIFY marks a way most-recently-used, REPLACE asks the LRU for a victim
   typedef enum logic {
      MODIFY  = 1'b0,
      REPLACE = 1'b1
   } LRU_func_t;

   // Clear the word-offset and byte-offset bits of a line (line_words is a power of two)
   function automatic logic [31:0] line_base(input logic [31:0] addr, input int line_words);
      return addr & ~((32'(line_words) << 2) - 32'd1);
   endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Bus bundle between the refill controller and the rest of the I-cache.
// Handshakes: a lookup is taken on a cycle where req_valid && req_ready; a
// burst request is taken on a cycle where mem_req && mem_ready, and mem_req
// stays high with a stable mem_addr until then; a read beat is consumed on
// every cycle mem_rvalid is high (no ready on the return path).
interface icache_refill_ctrl_if
   import icache_refill_ctrl_pkg::*;
#(
   parameter int INDEX_BIT    = ICache_index_bit,
   parameter int POSITION_BIT = ICache_position_bit,
   parameter int LINE_WORDS   = 4
) ();

   localparam int OFF_BIT = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

   logic                    req_valid;
   logic                    req_ready;
   logic [31:0]             req_addr;
   logic                    tag_hit;
   logic [POSITION_BIT-1:0] tag_hit_way;
   logic                    lru_not_funct_en;
   LRU_func_t               lru_func;
   logic [INDEX_BIT-1:0]    lru_index;
   logic [POSITION_BIT-1:0] lru_hit_pos;
   logic [POSITION_BIT-1:0] lru_pos;
   logic                    mem_req;
   logic [31:0]             mem_addr;
   logic                    mem_ready;
   logic                    mem_rvalid;
   logic [31:0]             mem_rdata;
   logic                    mem_rlast;
   logic                    data_we;
   logic [POSITION_BIT-1:0] data_way;
   logic [INDEX_BIT-1:0]    data_index;
   logic [OFF_BIT-1:0]      data_offset;
   logic [31:0]             data_wdata;
   logic                    tag_we;
   logic                    resp_valid;
   logic [POSITION_BIT-1:0] resp_way;
   logic                    refill_err;

   // The refill controller side
   modport master (
      input  req_valid, req_addr, tag_hit, tag_hit_way, lru_pos,
             mem_ready, mem_rvalid, mem_rdata, mem_rlast,
      output req_ready, lru_not_funct_en, lru_func, lru_index, lru_hit_pos,
             mem_req, mem_addr, data_we, data_way, data_index, data_offset,
             data_wdata, tag_we, resp_valid, resp_way, refill_err
   );

   // Fetch unit, tag/data arrays, LRU and memory side
   modport slave (
      output req_valid, req_addr, tag_hit, tag_hit_way, lru_pos,
             mem_ready, mem_rvalid, mem_rdata, mem_rlast,
      input  req_ready, lru_not_funct_en, lru_func, lru_index, lru_hit_pos,
             mem_req, mem_addr, data_we, data_way, data_index, data_offset,
             data_wdata, tag_we, resp_valid, resp_way, refill_err
   );

endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache refill controller: answers hits in one cycle, and on a miss asks
// the LRU for a victim, bursts the line from memory into the data array and
// finally writes the tag. A reset mid-burst leaves the line without its tag.
module icache_refill_ctrl
   import icache_refill_ctrl_pkg::*;
#(
   parameter int INDEX_BIT    = ICache_index_bit,
   parameter int POSITION_BIT = ICache_position_bit,
   parameter int LINE_WORDS   = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   icache_refill_ctrl_if.master bus,
   output logic [2:0]           dbg_state_o
);

   localparam int OFF_BIT    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int LINE_SHIFT = OFF_BIT + 2;
   localparam logic [OFF_BIT-1:0] LAST_BEAT = OFF_BIT'(LINE_WORDS - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_VICTIM  = 3'd1;
   localparam logic [2:0] S_MEM_REQ = 3'd2;
   localparam logic [2:0] S_REFILL  = 3'd3;
   localparam logic [2:0] S_COMMIT  = 3'd4;

   logic [2:0]              state_q, state_d;
   logic [31:0]             addr_q, addr_d;
   logic [POSITION_BIT-1:0] victim_q, victim_d;
   logic [OFF_BIT-1:0]      beat_q, beat_d;
   logic                    err_q, err_d;
   logic                    resp_q, resp_d;
   logic [POSITION_BIT-1:0] resp_way_q, resp_way_d;

   logic                    req_fire;
   logic                    hit_fire;
   logic                    beat_fire;
   logic                    last_beat;
   logic [INDEX_BIT-1:0]    req_index;
   logic [INDEX_BIT-1:0]    lat_index;

   assign req_fire  = (state_q == S_IDLE) && bus.req_valid;
   assign hit_fire  = req_fire && bus.tag_hit;
   assign beat_fire = (state_q == S_REFILL) && bus.mem_rvalid;
   assign last_beat = (beat_q == LAST_BEAT);
   assign req_index = bus.req_addr[LINE_SHIFT +: INDEX_BIT];
   assign lat_index = addr_q[LINE_SHIFT +: INDEX_BIT];

   // Next-state logic: FSM transitions, request latch, beat count, error flag
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      victim_d   = victim_q;
      beat_d     = beat_q;
      err_d      = err_q;
      resp_d     = hit_fire;
      resp_way_d = hit_fire ? bus.tag_hit_way : '0;
      case (state_q)
         S_IDLE: begin
            if (req_fire) begin
               addr_d = bus.req_addr;
               if (!bus.tag_hit) state_d = S_VICTIM;
            end
         end
         S_VICTIM: begin
            victim_d = bus.lru_pos;
            state_d  = S_MEM_REQ;
         end
         S_MEM_REQ: begin
            if (bus.mem_ready) begin
               beat_d  = '0;
               state_d = S_REFILL;
            end
         end
         S_REFILL: begin
            if (bus.mem_rvalid) begin
               beat_d = beat_q + OFF_BIT'(1);
               // rlast must mark exactly the final beat; the count decides completion
               if (bus.mem_rlast != last_beat) err_d = 1'b1;
               if (last_beat) state_d = S_COMMIT;
            end
         end
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         victim_q   <= '0;
         beat_q     <= '0;
         err_q      <= 1'b0;
         resp_q     <= 1'b0;
         resp_way_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         victim_q   <= victim_d;
         beat_q     <= beat_d;
         err_q      <= err_d;
         resp_q     <= resp_d;
         resp_way_q <= resp_way_d;
      end
   end

   // Output decode from state and same-cycle handshakes
   always_comb begin
      bus.req_ready        = (state_q == S_IDLE);
      bus.lru_not_funct_en = !(hit_fire || (state_q == S_VICTIM));
      bus.lru_func         = (state_q == S_VICTIM) ? REPLACE : MODIFY;
      bus.lru_index        = hit_fire ? req_index :
                             ((state_q == S_VICTIM) ? lat_index : '0);
      bus.lru_hit_pos      = hit_fire ? bus.tag_hit_way : '0;
      bus.mem_req          = (state_q == S_MEM_REQ);
      bus.mem_addr         = (state_q == S_MEM_REQ) ? line_base(addr_q, LINE_WORDS) : '0;
      bus.data_we          = beat_fire;
      bus.data_way         = victim_q;
      bus.data_index       = lat_index;
      bus.data_offset      = beat_q;
      bus.data_wdata       = beat_fire ? bus.mem_rdata : '0;
      bus.tag_we           = (state_q == S_COMMIT);
      bus.resp_valid       = resp_q || (state_q == S_COMMIT);
      bus.resp_way         = (state_q == S_COMMIT) ? victim_q : resp_way_q;
      bus.refill_err       = err_q;
      dbg_state_o          = state_q;
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: reset state, a table of hit lookups, scripted
// miss/stall/error/abort sequences and a randomized mix of hits and misses.
module tb_icache_refill_ctrl;
   import icache_refill_ctrl_pkg::*;

   logic       clk;
   logic       resetn;
   logic [2:0] dbg_state;

   icache_refill_ctrl_if bus ();

   icache_refill_ctrl dut (
      .clk        (clk),
      .resetn     (resetn),
      .bus        (bus),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [43:0] exp_q[$];      // {way, index, offset, data} of each expected line write
   logic        err_model = 1'b0;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  way;
      logic [7:0]  exp_index;
   } hit_vec_t;

   hit_vec_t hv[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference rules: set index is the line number modulo the set count,
   // the burst address is the address rounded down to a 16-byte line.
   function automatic logic [7:0] idx_of(input logic [31:0] a);
      return 8'((a / 32'd16) % 32'd256);
   endfunction

   function automatic logic [31:0] base_of(input logic [31:0] a);
      return a - (a % 32'd16);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      #4;
   endtask

   task automatic idle_inputs();
      bus.req_valid   = 1'b0;
      bus.req_addr    = '0;
      bus.tag_hit     = 1'b0;
      bus.tag_hit_way = '0;
      bus.lru_pos     = '0;
      bus.mem_ready   = 1'b0;
      bus.mem_rvalid  = 1'b0;
      bus.mem_rdata   = '0;
      bus.mem_rlast   = 1'b0;
   endtask

   task automatic hit_txn(input logic [31:0] addr, input logic [1:0] way, input logic [7:0] exp_idx);
      bus.req_valid   = 1'b1;
      bus.tag_hit     = 1'b1;
      bus.req_addr    = addr;
      bus.tag_hit_way = way;
      bus.lru_pos     = 2'($urandom);
      sample();
      chk("hit_req_ready", 64'(bus.req_ready), 64'd1);
      chk("hit_lru_en", 64'(bus.lru_not_funct_en), 64'd0);
      chk("hit_lru_func", 64'(bus.lru_func), 64'(MODIFY));
      chk("hit_lru_pos", 64'(bus.lru_hit_pos), 64'(way));
      chk("hit_lru_index", 64'(bus.lru_index), 64'(exp_idx));
      chk("hit_no_mem_req", 64'(bus.mem_req), 64'd0);
      tick();
      bus.req_valid = 1'b0;
      bus.tag_hit   = 1'b0;
      sample();
      chk("hit_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("hit_resp_way", 64'(bus.resp_way), 64'(way));
      chk("hit_lru_hold", 64'(bus.lru_not_funct_en), 64'd1);
      tick();
      sample();
      chk("hit_resp_pulse", 64'(bus.resp_valid), 64'd0);
      tick();
   endtask

   // One miss: victim pick, burst request with ready_wait stalls, four beats
   // with gaps in [gap_lo,gap_hi], rlast on beat rlast_pos (4 = never), and an
   // optional reset right after beat abort_after (-1 = run to completion).
   task automatic miss_txn(input logic [31:0] addr, input logic [1:0] victim,
                           input int ready_wait, input int gap_lo, input int gap_hi,
                           input int rlast_pos, input bit fixed_data, input int abort_after);
      logic [7:0]  idx;
      logic [31:0] base;
      logic [31:0] data;
      logic [43:0] exp_w;
      idx  = idx_of(addr);
      base = base_of(addr);
      // lookup misses
      bus.req_valid = 1'b1;
      bus.tag_hit   = 1'b0;
      bus.req_addr  = addr;
      bus.lru_pos   = ~victim;
      sample();
      chk("miss_req_ready", 64'(bus.req_ready), 64'd1);
      chk("miss_no_lru", 64'(bus.lru_not_funct_en), 64'd1);
      tick();
      // victim cycle; the fetch unit keeps requesting with unrelated inputs
      bus.req_addr    = $urandom;
      bus.tag_hit     = 1'($urandom_range(0, 1));
      bus.tag_hit_way = 2'($urandom);
      bus.lru_pos     = victim;
      sample();
      chk("victim_req_ready", 64'(bus.req_ready), 64'd0);
      chk("victim_lru_en", 64'(bus.lru_not_funct_en), 64'd0);
      chk("victim_lru_func", 64'(bus.lru_func), 64'(REPLACE));
      chk("victim_lru_index", 64'(bus.lru_index), 64'(idx));
      chk("victim_no_mem_req", 64'(bus.mem_req), 64'd0);
      tick();
      bus.lru_pos = 2'($urandom);
      // burst request, stalled by the memory
      for (int w = 0; w < ready_wait; w++) begin
         bus.mem_ready  = 1'b0;
         bus.mem_rvalid = 1'($urandom_range(0, 1));
         bus.mem_rdata  = $urandom;
         bus.req_addr   = $urandom;
         sample();
         chk("stall_mem_req", 64'(bus.mem_req), 64'd1);
         chk("stall_mem_addr", 64'(bus.mem_addr), 64'(base));
         chk("stall_no_we", 64'(bus.data_we), 64'd0);
         chk("stall_lru_hold", 64'(bus.lru_not_funct_en), 64'd1);
         chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
         tick();
      end
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = 1'b0;
      sample();
      chk("mem_req", 64'(bus.mem_req), 64'd1);
      chk("mem_addr", 64'(bus.mem_addr), 64'(base));
      tick();
      bus.mem_ready = 1'b0;
      // beats
      for (int b = 0; b < 4; b++) begin
         int gaps;
         gaps = $urandom_range(gap_lo, gap_hi);
         for (int g = 0; g < gaps; g++) begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rlast  = 1'($urandom_range(0, 1));
            sample();
            chk("gap_no_we", 64'(bus.data_we), 64'd0);
            chk("gap_no_mem_req", 64'(bus.mem_req), 64'd0);
            chk("gap_lru_hold", 64'(bus.lru_not_funct_en), 64'd1);
            chk("gap_req_ready", 64'(bus.req_ready), 64'd0);
            chk("gap_no_tag_we", 64'(bus.tag_we), 64'd0);
            tick();
         end
         data           = fixed_data ? (32'hA0 + 32'(b)) : $urandom;
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = data;
         bus.mem_rlast  = (b == rlast_pos);
         exp_q.push_back({victim, idx, 2'(b), data});
         if ((b == 3) != (b == rlast_pos)) err_model = 1'b1;
         sample();
         chk("beat_we", 64'(bus.data_we), 64'd1);
         if (bus.data_we) begin
            if (exp_q.size() == 0) begin
               chk("beat_unexpected", 64'd1, 64'd0);
            end else begin
               exp_w = exp_q.pop_front();
               chk("beat_write", 64'({bus.data_way, bus.data_index, bus.data_offset, bus.data_wdata}),
                   64'(exp_w));
            end
         end
         chk("beat_lru_hold", 64'(bus.lru_not_funct_en), 64'd1);
         tick();
         if (b == abort_after) begin
            bus.mem_rvalid = 1'b0;
            bus.req_valid  = 1'b0;
            resetn         = 1'b0;
            sample();
            chk("abort_no_tag_we", 64'(bus.tag_we), 64'd0);
            tick();
            resetn    = 1'b1;
            err_model = 1'b0;
            exp_q.delete();
            sample();
            chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
            chk("abort_no_tag_we2", 64'(bus.tag_we), 64'd0);
            chk("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
            chk("abort_err_clear", 64'(bus.refill_err), 64'd0);
            chk("abort_mem_req", 64'(bus.mem_req), 64'd0);
            tick();
            return;
         end
      end
      // commit
      bus.mem_rvalid = 1'b0;
      bus.req_valid  = 1'b0;
      bus.tag_hit    = 1'b0;
      sample();
      chk("commit_tag_we", 64'(bus.tag_we), 64'd1);
      chk("commit_way", 64'(bus.data_way), 64'(victim));
      chk("commit_index", 64'(bus.data_index), 64'(idx));
      chk("commit_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("commit_resp_way", 64'(bus.resp_way), 64'(victim));
      chk("commit_err", 64'(bus.refill_err), 64'(err_model));
      chk("commit_no_we", 64'(bus.data_we), 64'd0);
      chk("commit_lru_hold", 64'(bus.lru_not_funct_en), 64'd1);
      tick();
      // back in idle; a stray beat must be ignored
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
      sample();
      chk("post_req_ready", 64'(bus.req_ready), 64'd1);
      chk("post_tag_we", 64'(bus.tag_we), 64'd0);
      chk("post_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("post_stray_beat", 64'(bus.data_we), 64'd0);
      chk("post_all_written", 64'(exp_q.size()), 64'd0);
      tick();
      bus.mem_rvalid = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      hv[0] = '{addr: 32'h0000_1040, way: 2'd2, exp_index: 8'h04};
      hv[1] = '{addr: 32'h0000_0FF0, way: 2'd0, exp_index: 8'hFF};
      hv[2] = '{addr: 32'h1234_5678, way: 2'd1, exp_index: 8'h67};
      hv[3] = '{addr: 32'hFFFF_FFFF, way: 2'd3, exp_index: 8'hFF};
      hv[4] = '{addr: 32'h0000_0000, way: 2'd3, exp_index: 8'h00};
      hv[5] = '{addr: 32'h0000_100C, way: 2'd1, exp_index: 8'h00};

      idle_inputs();
      resetn = 1'b0;
      tick();
      tick();
      sample();
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_lru_en", 64'(bus.lru_not_funct_en), 64'd1);
      chk("rst_lru_func", 64'(bus.lru_func), 64'd0);
      chk("rst_lru_index", 64'(bus.lru_index), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_data_we", 64'(bus.data_we), 64'd0);
      chk("rst_data_way", 64'(bus.data_way), 64'd0);
      chk("rst_data_offset", 64'(bus.data_offset), 64'd0);
      chk("rst_tag_we", 64'(bus.tag_we), 64'd0);
      chk("rst_refill_err", 64'(bus.refill_err), 64'd0);
      tick();
      resetn = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) hit_txn(hv[i].addr, hv[i].way, hv[i].exp_index);

      // basic miss with known beat data
      miss_txn(32'h0000_2010, 2'd3, 0, 0, 0, 3, 1'b1, -1);
      // memory stalls: ready late, one idle cycle between beats
      miss_txn(32'h0000_3450, 2'd1, 5, 1, 1, 3, 1'b0, -1);
      // rlast on beat 2: error raised, line still completes
      miss_txn(32'h0000_4000, 2'd0, 1, 0, 0, 2, 1'b0, -1);
      // error stays set across a later clean refill
      miss_txn(32'h0000_4100, 2'd2, 0, 0, 1, 3, 1'b0, -1);
      // reset after beat 1, then a clean refill
      miss_txn(32'h0000_5670, 2'd2, 0, 0, 1, 3, 1'b0, 1);
      miss_txn(32'h0000_2010, 2'd2, 2, 0, 2, 3, 1'b1, -1);
      hit_txn(32'h0000_2010, 2'd2, 8'h01);

      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            hit_txn(a, 2'($urandom), idx_of(a));
         end else begin
            int rl;
            int ab;
            rl = ($urandom_range(0, 9) < 7) ? 3 : int'($urandom_range(0, 4));
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1;
            miss_txn(a, 2'($urandom), $urandom_range(0, 4), 0, $urandom_range(0, 2), rl, 1'b0, ab);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard stop in case a task ever loses track of time
   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1);
   end

endmodule
